id_decode: RTL and testbench

//  Instruction-decode stage directly downstream of the fetch unit. Latches the fetched
//  32-bit instruction and its 14-bit word address into an IF/ID register with stall/flush.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/regfile_32x32.sv | 38 +++
 rtl/id_decode.sv | 91 +++++++++
 tb/tb_id_decode.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcode values, the bubble instruction,
// immediate formats and opcode classification helpers.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] op);
    imm_type_e t;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: t = IMM_I;
      OP_STORE:                            t = IMM_S;
      OP_BRANCH:                           t = IMM_B;
      OP_LUI, OP_AUIPC:                    t = IMM_U;
      OP_JAL:                              t = IMM_J;
      default:                             t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic is_rv32i(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register file, 2 async read / 1 sync write, x0 hardwired to zero.
// REGFILE_BYPASS_EN: reads see a same-cycle write (write-through); otherwise the stored value.
module regfile_32x32 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [1:31];

  // rst_n is the legacy name of an active-high reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int k = 1; k < 32; k++) r_regs[k] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 :
                    (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 :
                    (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
`else
  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];
`endif

endmodule

// File: rtl/id_decode.sv
// RV32I decode stage: IF/ID register (flush beats stall), regfile, immediate/control fields; 1-cycle latency.
// Stall holds IF/ID, flush inserts a bubble; optional REGFILE_BYPASS_EN write-through in regfile_32x32.
module id_decode #(
  parameter int          ADDR_W   = 14,
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic              funct7b5_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [31:0]       imm_o,
  output logic              illegal_o
);
  import cpu_pkg::*;

  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic              r_vld;

  logic [6:0]  w_opcode;
  logic [31:0] w_imm;

  // pc is captured even on flush so a bubble still carries the redirect address
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_instr <= NOP_INSN;
      r_pc    <= '0;
      r_vld   <= 1'b0;
    end else if (flush_i) begin
      r_instr <= NOP_INSN;
      r_pc    <= pc_i;
      r_vld   <= 1'b0;
    end else if (!stall_i) begin
      r_instr <= instr_i;
      r_pc    <= pc_i;
      r_vld   <= 1'b1;
    end
  end

  assign w_opcode = r_instr[6:0];

  always_comb begin
    w_imm = '0;
    case (imm_type_of(w_opcode))
      IMM_I:   w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      IMM_S:   w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      IMM_B:   w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                        r_instr[11:8], 1'b0};
      IMM_U:   w_imm = {r_instr[31:12], 12'b0};
      IMM_J:   w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                        r_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  regfile_32x32 #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (wb_en_i),
    .i_waddr  (wb_rd_i),
    .i_wdata  (wb_data_i),
    .i_raddr1 (r_instr[19:15]),
    .i_raddr2 (r_instr[24:20]),
    .o_rdata1 (rs1_data_o),
    .o_rdata2 (rs2_data_o)
  );

  assign valid_o    = r_vld;
  assign pc_o       = r_pc;
  assign opcode_o   = w_opcode;
  assign rd_o       = r_instr[11:7];
  assign funct3_o   = r_instr[14:12];
  assign funct7b5_o = r_instr[30];
  assign imm_o      = w_imm;
  assign illegal_o  = r_vld && !is_rv32i(w_opcode);

endmodule

// File: tb/tb_id_decode.sv
// Bench for id_decode: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i;
  logic [13:0] pc_i;
  logic        stall_i, flush_i, wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        valid_o, funct7b5_o, illegal_o;
  logic [13:0] pc_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_instr;
  logic [13:0] m_pc;
  logic        m_vld;
  logic [31:0] m_regs [32];

  logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};

  always #5 clk = ~clk;

  id_decode dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .wb_en_i(wb_en_i),
    .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .valid_o(valid_o),
    .pc_o(pc_o), .opcode_o(opcode_o), .rd_o(rd_o), .funct3_o(funct3_o),
    .funct7b5_o(funct7b5_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .illegal_o(illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic op_legal(input logic [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Immediate built arithmetically from the instruction's sign and field positions.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [31:0] s;
    logic [31:0] sx;
    s  = i;
    sx = s >>> 31;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 32'(s >>> 20);
      7'h23: return ((32'(s >>> 25)) << 5) | 32'(i[11:7]);
      7'h63: return (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      7'h37, 7'h17: return i & 32'hFFFFF000;
      7'h6F: return (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_rs(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en_i && wb_rd_i == idx) return wb_data_i;
`endif
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    m_instr = 32'h00000013;
    m_pc    = '0;
    m_vld   = 1'b0;
    foreach (m_regs[k]) m_regs[k] = '0;
  endtask

  task automatic model_step();
    if (rst_n) begin
      model_reset();
    end else begin
      if (wb_en_i && wb_rd_i != 5'd0) m_regs[wb_rd_i] = wb_data_i;
      if (flush_i) begin
        m_instr = 32'h00000013; m_pc = pc_i; m_vld = 1'b0;
      end else if (!stall_i) begin
        m_instr = instr_i; m_pc = pc_i; m_vld = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("valid",   32'(valid_o),    32'(m_vld));
    check("pc",      32'(pc_o),       32'(m_pc));
    check("opcode",  32'(opcode_o),   32'(m_instr[6:0]));
    check("rd",      32'(rd_o),       32'(m_instr[11:7]));
    check("funct3",  32'(funct3_o),   32'(m_instr[14:12]));
    check("f7b5",    32'(funct7b5_o), 32'(m_instr[30]));
    check("rs1",     rs1_data_o,      ref_rs(m_instr[19:15]));
    check("rs2",     rs2_data_o,      ref_rs(m_instr[24:20]));
    check("imm",     imm_o,           ref_imm(m_instr));
    check("illegal", 32'(illegal_o),  32'(m_vld && !op_legal(m_instr[6:0])));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic load(input logic [31:0] ins, input logic [13:0] pc);
    instr_i = ins; pc_i = pc; stall_i = 1'b0; flush_i = 1'b0;
    cyc();
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b1; instr_i = '0; pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_opcode", 32'(opcode_o), 32'h13);
    check("rst_valid",  32'(valid_o),  32'd0);
    rst_n = 1'b0;

    // addi x1,x0,-1
    load(32'hFFF00093, 14'd5);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    check("addi_rd",  32'(rd_o), 32'd1);
    check("addi_pc",  32'(pc_o), 32'd5);
    check("addi_vld", 32'(valid_o), 32'd1);
    check("addi_ill", 32'(illegal_o), 32'd0);

    stall_i = 1'b1; instr_i = 32'h12345037; pc_i = 14'd99;
    cyc();
    check("stall_pc",  32'(pc_o), 32'd5);
    check("stall_imm", imm_o, 32'hFFFFFFFF);
    flush_i = 1'b1;
    cyc();
    check("flush_vld", 32'(valid_o), 32'd0);
    check("flush_op",  32'(opcode_o), 32'h13);

    // add x0,x5,x0 then write x5 while it is being read
    load(32'h00028033, 14'd7);
    wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEADBEEF; stall_i = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same", rs1_data_o, 32'hDEADBEEF);
`else
    check("nobypass_same", rs1_data_o, 32'd0);
`endif
    cyc();
    wb_en_i = 1'b0;
    #1;
    check("wb_next", rs1_data_o, 32'hDEADBEEF);
    wb_en_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'd1;
    cyc();
    wb_en_i = 1'b0;
    #1;
    check("x0_zero", rs2_data_o, 32'd0);

    load(32'hFE000EE3, 14'd10);
    check("beq_imm", imm_o, 32'hFFFFFFFC);
    load(32'h0080006F, 14'd11);
    check("jal_imm", imm_o, 32'd8);
    load(32'h00112623, 14'd12);
    check("sw_imm", imm_o, 32'd12);

    load(32'h0000007F, 14'd13);
    check("ill_set", 32'(illegal_o), 32'd1);
    flush_i = 1'b1;
    cyc();
    check("ill_flush", 32'(illegal_o), 32'd0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      if ($urandom_range(0, 7) == 0) instr_i = r;
      else instr_i = {r[31:7], legal_ops[$urandom_range(0, 9)]};
      pc_i      = 14'($urandom());
      stall_i   = ($urandom_range(0, 3) == 0);
      flush_i   = ($urandom_range(0, 9) == 0);
      wb_en_i   = ($urandom_range(0, 1) == 1);
      wb_rd_i   = ($urandom_range(0, 3) == 0) ? m_instr[19:15] : 5'($urandom_range(0, 31));
      wb_data_i = $urandom();
      #1;
      check_all();
      cyc();
    end

    wb_en_i = 1'b0;
    load(32'h01F28033, 14'd21);
    check("pre_rst_vld", 32'(valid_o), 32'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rst_vld", 32'(valid_o), 32'd0);
    check("mid_rst_pc",  32'(pc_o), 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b0;
    load(32'h01F28033, 14'd22);
    check("rst_x5", rs1_data_o, 32'd0);
    check("rst_x31", rs2_data_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
